// File: rtl/mux8way_arb_if.sv
// Handshake bundle for mux8way_arb: eight request channels in, one tagged stream out.
interface mux8way_arb_if #(
    parameter int WIDTH = 16
);
    logic [7:0]         in_valid;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );
endinterface

// File: rtl/mux8way_arb.sv
// Eight-to-one round-robin word collector with a registered, source-tagged output.
// Define MUX8ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration (ptr frozen at 0).
module mux8way_arb #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    mux8way_arb_if.slave bus
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr_q, ptr_d;

    logic             load;
    logic             found;
    logic [2:0]       idx;
    logic [2:0]       gidx;
    logic [7:0]       grant;
    logic [WIDTH-1:0] word;

    // Rotate-priority encode starting at ptr; never looks at in_data.
    always_comb begin
        load  = ~vld_q | bus.out_ready;
        found = 1'b0;
        gidx  = '0;
        idx   = ptr_q;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        grant = '0;
        if (load && found) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        word = '0;
        for (int i = 0; i < 8; i++) begin
            if (gidx == 3'(i)) begin
                word = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        if (load && found) begin
            vld_d  = 1'b1;
            data_d = word;
            sel_d  = gidx;
`ifdef MUX8ARB_FIXED_PRIORITY_EN
            ptr_d  = ptr_q;
`else
            ptr_d  = gidx + 3'd1;
`endif
        end else if (load) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            sel_q  <= '0;
            ptr_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
        end
    end

    assign bus.in_ready  = grant;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux8way_arb.sv
// Directed bench for mux8way_arb: reset, round-robin, wrap, backpressure, drain, sparse.
module tb_mux8way_arb;

`ifdef MUX8ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_run;
    int   n_fail;

    mux8way_arb_if #(.WIDTH(16)) bus ();

    mux8way_arb #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [15:0] w);
        bus.in_data[ch*16 +: 16] = w;
    endtask

    task automatic pulse_reset();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
    endtask

    logic [7:0] exp_rdy;
    logic [2:0] exp_sel;

    initial begin
        n_run         = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_vld", 32'(bus.out_valid), 0);
        chk("rst_rdy", 32'(bus.in_ready), 0);

        // Reset while a word is held
        set_word(3, 16'h1234);
        bus.in_valid = 8'h08;
        step();
        bus.in_valid = 8'h00;
        chk("pre_vld", 32'(bus.out_valid), 1);
        chk("pre_sel", 32'(bus.out_sel), 3);
        reset = 1'b1;
        #1;
        chk("async_vld", 32'(bus.out_valid), 0);
        chk("async_data", 32'(bus.out_data), 0);
        chk("async_sel", 32'(bus.out_sel), 0);
        chk("async_rdy", 32'(bus.in_ready), 0);
        reset = 1'b0;
        bus.in_valid = 8'h08;
        #1;
        chk("post_rdy", 32'(bus.in_ready), 32'h08);
        step();
        bus.in_valid = 8'h00;
        chk("post_data", 32'(bus.out_data), 32'h1234);
        chk("post_sel", 32'(bus.out_sel), 3);

        // Full load
        pulse_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) set_word(i, 16'hA000 + 16'(i));
        bus.in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            exp_sel = FIXED ? 3'd0 : 3'(k % 8);
            exp_rdy = 8'h01 << exp_sel;
            #1;
            chk($sformatf("rr_rdy%0d", k), 32'(bus.in_ready), 32'(exp_rdy));
            step();
            chk($sformatf("rr_sel%0d", k), 32'(bus.out_sel), 32'(exp_sel));
            chk($sformatf("rr_dat%0d", k), 32'(bus.out_data),
                32'(16'hA000 + 16'(exp_sel)));
        end
        bus.in_valid = 8'h00;

        // Pointer wrap
        pulse_reset();
        bus.in_valid = 8'h80;
        step();
        chk("wrap_sel7", 32'(bus.out_sel), 7);
        bus.in_valid = 8'h81;
        step();
        chk("wrap_sel0", 32'(bus.out_sel), 0);
        step();
        chk("wrap_selb", 32'(bus.out_sel), FIXED ? 0 : 7);
        bus.in_valid = 8'h00;

        // Backpressure
        pulse_reset();
        set_word(5, 16'hBEEF);
        set_word(1, 16'h1111);
        set_word(7, 16'h7777);
        bus.in_valid = 8'h20;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 8'h82;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_rdy%0d", k), 32'(bus.in_ready), 0);
            step();
            chk($sformatf("bp_dat%0d", k), 32'(bus.out_data), 32'hBEEF);
            chk($sformatf("bp_sel%0d", k), 32'(bus.out_sel), 5);
            chk($sformatf("bp_vld%0d", k), 32'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 32'(bus.in_ready), FIXED ? 32'h02 : 32'h80);
        step();
        bus.in_valid = 8'h00;
        chk("bp_rel_vld", 32'(bus.out_valid), 1);
        chk("bp_rel_sel", 32'(bus.out_sel), FIXED ? 1 : 7);
        chk("bp_rel_dat", 32'(bus.out_data), FIXED ? 32'h1111 : 32'h7777);

        // Drain to empty
        step();
        chk("dr_empty", 32'(bus.out_valid), 0);
        set_word(2, 16'h5A5A);
        bus.in_valid = 8'h04;
        step();
        bus.in_valid = 8'h00;
        chk("dr_vld1", 32'(bus.out_valid), 1);
        chk("dr_sel", 32'(bus.out_sel), 2);
        step();
        chk("dr_vld0", 32'(bus.out_valid), 0);
        chk("dr_hold", 32'(bus.out_data), 32'h5A5A);
        chk("dr_hsel", 32'(bus.out_sel), 2);

        // Sparse fairness between channels 2 and 6
        pulse_reset();
        bus.in_valid = 8'h44;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_sel = (FIXED || (k % 2 == 0)) ? 3'd2 : 3'd6;
            chk($sformatf("sp_sel%0d", k), 32'(bus.out_sel), 32'(exp_sel));
        end
        bus.in_valid = 8'h00;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
